clk_freq_monitor: RTL and testbench

//  Multi-channel clock supervisor in the clk_ref domain: measures each test clock's rate over a common gate window.

---
 rtl/clk_freq_monitor.sv | 185 ++++++++++++++++++
 tb/tb_clk_freq_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// Multi-channel clock frequency supervisor in the clk_ref domain.
// Every channel counts its synchronised clk_div rising edges over a shared gate
// window. The count is checked against min/max limits, lock-loss events are
// counted, and sticky alarms plus a small register port are provided.
module clk_freq_monitor #(
    parameter int unsigned NCLK        = 4,
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned PRESCALE    = 3,
    parameter int unsigned CNT_W       = 24
) (
    input  logic                      clk_ref,
    input  logic                      reset,
    input  logic [NCLK-1:0]           clk_div,
    input  logic [NCLK-1:0]           locked,
    input  logic                      reg_wr,
    input  logic                      reg_rd,
    input  logic [$clog2(NCLK*4)-1:0] reg_addr,
    input  logic [31:0]               reg_wdata,
    output logic [31:0]               reg_rdata,
    output logic                      reg_rdack,
    output logic                      reg_wrack,
    output logic [NCLK-1:0]           alarm,
    output logic                      irq
);

    localparam int unsigned AW = $clog2(NCLK*4);
    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        REG_RATE    = 2'd0,
        REG_UNLOCKS = 2'd1,
        REG_LIMITS  = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_t;

    // Reported rate is the raw count scaled back by the prescaler, clipped to CNT_W bits.
    function automatic logic [CNT_W-1:0] scale_rate(input logic [CNT_W-1:0] raw_cnt);
        logic [63:0] wide;
        wide = 64'(raw_cnt) << PRESCALE;
        if ((wide >> CNT_W) != 64'd0) return CNT_MAX;
        return wide[CNT_W-1:0];
    endfunction

    // Limits are 16 bits wide, so the raw count is clipped to 0xFFFF before comparing.
    function automatic logic [15:0] clip16(input logic [CNT_W-1:0] raw_cnt);
        logic [31:0] wide;
        wide = 32'(raw_cnt);
        if (wide > 32'h0000_FFFF) return 16'hFFFF;
        return wide[15:0];
    endfunction

    logic [NCLK-1:0]  div_s1, div_s2, div_h;
    logic [NCLK-1:0]  lk_s1, lk_s2, lk_h;
    logic [NCLK-1:0]  rise, fall;
    logic [GW-1:0]    gate_cnt;
    logic             terminal;
    logic             valid;
    logic [CNT_W-1:0] edge_cnt [NCLK];
    logic [CNT_W-1:0] cnt_next [NCLK];
    logic [CNT_W-1:0] raw      [NCLK];
    logic [15:0]      lim_min  [NCLK];
    logic [15:0]      lim_max  [NCLK];
    logic [31:0]      unlocks  [NCLK];
    logic [NCLK-1:0]  pend_slow, pend_fast;
    logic [NCLK-1:0]  too_slow, too_fast, unlock;
    logic [AW-1:0]    ch_addr;
    reg_sel_t         reg_sel;
    logic [NCLK-1:0]  wr_unl, wr_lim, wr_st;
    logic [31:0]      rd_mux;

    assign rise     = div_s2 & ~div_h;
    assign fall     = lk_h & ~lk_s2;
    assign terminal = (gate_cnt == GATE_LAST);
    assign ch_addr  = reg_addr >> 2;
    assign reg_sel  = reg_sel_t'(reg_addr[1:0]);
    assign alarm    = too_slow | too_fast | unlock;
    assign irq      = |alarm;

    // Two-flop synchronisers plus one history flop per input for edge detection.
    always_ff @(posedge clk_ref) begin
        if (reset) begin
            div_s1 <= '0; div_s2 <= '0; div_h <= '0;
            lk_s1  <= '0; lk_s2  <= '0; lk_h  <= '0;
        end else begin
            div_s1 <= clk_div; div_s2 <= div_s1; div_h <= div_s2;
            lk_s1  <= locked;  lk_s2  <= lk_s1;  lk_h  <= lk_s2;
        end
    end

    // Saturating edge-count increment, shared by the running counter and the window latch.
    always_comb begin
        for (int unsigned c = 0; c < NCLK; c++) begin
            cnt_next[c] = edge_cnt[c];
            if (rise[c] && (edge_cnt[c] != CNT_MAX)) cnt_next[c] = edge_cnt[c] + 1'b1;
        end
    end

    // Address decode: per-channel write strobes and the read-data mux (unmapped channels read 0).
    always_comb begin
        wr_unl = '0;
        wr_lim = '0;
        wr_st  = '0;
        rd_mux = '0;
        for (int unsigned c = 0; c < NCLK; c++) begin
            if (ch_addr == AW'(c)) begin
                wr_unl[c] = reg_wr && (reg_sel == REG_UNLOCKS);
                wr_lim[c] = reg_wr && (reg_sel == REG_LIMITS);
                wr_st[c]  = reg_wr && (reg_sel == REG_STATUS);
                case (reg_sel)
                    REG_RATE: begin
                        rd_mux     = 32'(scale_rate(raw[c]));
                        rd_mux[31] = valid;
                    end
                    REG_UNLOCKS: rd_mux = unlocks[c];
                    REG_LIMITS:  rd_mux = {lim_max[c], lim_min[c]};
                    REG_STATUS:  rd_mux = {28'd0, unlock[c], too_fast[c], too_slow[c], lk_s2[c]};
                    default:     rd_mux = '0;
                endcase
            end
        end
    end

    // Gate window, per-channel counting, limit checks, lock-loss tracking and sticky status.
    always_ff @(posedge clk_ref) begin
        if (reset) begin
            gate_cnt  <= '0;
            valid     <= 1'b0;
            pend_slow <= '0;
            pend_fast <= '0;
            too_slow  <= '0;
            too_fast  <= '0;
            unlock    <= '0;
            for (int unsigned c = 0; c < NCLK; c++) begin
                edge_cnt[c] <= '0;
                raw[c]      <= '0;
                lim_min[c]  <= 16'h0000;
                lim_max[c]  <= 16'hFFFF;
                unlocks[c]  <= '0;
            end
        end else begin
            gate_cnt <= terminal ? '0 : gate_cnt + 1'b1;
            if (terminal) valid <= 1'b1;
            for (int unsigned c = 0; c < NCLK; c++) begin
                if (terminal) begin
                    raw[c]      <= cnt_next[c];
                    edge_cnt[c] <= '0;
                end else begin
                    edge_cnt[c] <= cnt_next[c];
                end
                // Compare against the limits held during the terminal cycle; the sticky bit
                // follows one cycle later so a W1C landing then loses to the set.
                pend_slow[c] <= terminal && (clip16(cnt_next[c]) < lim_min[c]);
                pend_fast[c] <= terminal && (clip16(cnt_next[c]) > lim_max[c]);
                too_slow[c]  <= pend_slow[c] | (too_slow[c] & ~(wr_st[c] & reg_wdata[1]));
                too_fast[c]  <= pend_fast[c] | (too_fast[c] & ~(wr_st[c] & reg_wdata[2]));
                unlock[c]    <= fall[c]      | (unlock[c]   & ~(wr_st[c] & reg_wdata[3]));
                if (wr_unl[c]) begin
                    unlocks[c] <= {31'd0, fall[c]};
                end else if (fall[c] && (unlocks[c] != 32'hFFFF_FFFF)) begin
                    unlocks[c] <= unlocks[c] + 32'd1;
                end
                if (wr_lim[c]) begin
                    lim_min[c] <= reg_wdata[15:0];
                    lim_max[c] <= reg_wdata[31:16];
                end
            end
        end
    end

    // Register port: read data and both acknowledges are registered one cycle after the strobe.
    always_ff @(posedge clk_ref) begin
        if (reset) begin
            reg_rdata <= '0;
            reg_rdack <= 1'b0;
            reg_wrack <= 1'b0;
        end else begin
            reg_rdata <= reg_rd ? rd_mux : '0;
            reg_rdack <= reg_rd;
            reg_wrack <= reg_wr;
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor with three channels (channel 3 is
// unmapped) and a 1000-cycle gate. Expected read data is queued when a read is
// issued and popped when the read acknowledge comes back.
module tb_clk_freq_monitor;

    localparam int unsigned NCLK = 3;
    localparam int unsigned GATE = 1000;

    logic            clk_ref = 1'b0;
    logic            reset;
    logic [NCLK-1:0] clk_div;
    logic [NCLK-1:0] locked;
    logic            reg_wr;
    logic            reg_rd;
    logic [3:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic            reg_rdack;
    logic            reg_wrack;
    logic [NCLK-1:0] alarm;
    logic            irq;

    int n_run    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rst_edge = 0;
    int ratio [NCLK] = '{10, 10, 0};
    int ph    [NCLK] = '{0, 3, 0};
    logic [31:0] exp_q [$];

    clk_freq_monitor #(
        .NCLK        (NCLK),
        .GATE_CYCLES (GATE),
        .PRESCALE    (3),
        .CNT_W       (24)
    ) dut (
        .clk_ref   (clk_ref),
        .reset     (reset),
        .clk_div   (clk_div),
        .locked    (locked),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_rdack (reg_rdack),
        .reg_wrack (reg_wrack),
        .alarm     (alarm),
        .irq       (irq)
    );

    initial forever #5 clk_ref = ~clk_ref;

    // Cycle counter and divided test clocks, synchronous to clk_ref at a fixed ratio per channel.
    initial begin
        clk_div = '0;
        forever begin
            @(posedge clk_ref);
            cyc++;
            #2;
            for (int c = 0; c < NCLK; c++) begin
                if (ratio[c] == 0) begin
                    clk_div[c] = 1'b0;
                end else begin
                    ph[c]      = (ph[c] + 1) % ratio[c];
                    clk_div[c] = (ph[c] < ratio[c] / 2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] adr(input int ch, input int r);
        return 4'(ch * 4 + r);
    endfunction

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    // Advance to cycle k counted from the last reset release (cycle 0 has gate count 0).
    task automatic go_to(input int k);
        int guard = 0;
        while (((cyc - rst_edge) < k) && (guard < 20000)) begin
            tick();
            guard++;
        end
    endtask

    task automatic reg_read(input logic [3:0] a, input logic [31:0] expv,
                            output logic [31:0] got, output logic [31:0] want, output logic ack);
        exp_q.push_back(expv);
        reg_addr = a;
        reg_rd   = 1'b1;
        tick();
        reg_rd = 1'b0;
        ack    = reg_rdack;
        got    = reg_rdata;
        want   = exp_q.pop_front();
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d, output logic ack);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        tick();
        reg_wr = 1'b0;
        ack    = reg_wrack;
    endtask

    task automatic test_reset();
        logic [31:0] g, w;
        logic a;
        reset = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0; locked = '1;
        repeat (4) tick();
        n_run++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", reg_rdata); end
        n_run++; if ({reg_rdack, reg_wrack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {reg_rdack, reg_wrack}); end
        n_run++; if ({alarm, irq} !== 4'b0000) begin n_fail++; $display("FAIL reset_alarm: got %b want 0000", {alarm, irq}); end
        reset = 1'b0;
        rst_edge = cyc;
        reg_read(adr(0, 0), 32'h0000_0000, g, w, a);
        n_run++; if (g !== w || a !== 1'b1) begin n_fail++; $display("FAIL reset_rate: got %h ack %b want %h", g, a, w); end
        reg_read(adr(0, 2), 32'hFFFF_0000, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL reset_limits: got %h want %h", g, w); end
        reg_write(adr(2, 1), 32'h0, a);
        n_run++; if (a !== 1'b1) begin n_fail++; $display("FAIL wrack: got %b want 1", a); end
        n_run++; if (reg_rdata !== 32'd0 || reg_rdack !== 1'b0) begin n_fail++; $display("FAIL rdata_idle: got %h/%b want 0/0", reg_rdata, reg_rdack); end
    endtask

    task automatic test_rate();
        logic [31:0] g, w;
        logic a;
        go_to(2005);
        reg_read(adr(0, 0), 32'h8000_0320, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL rate_ch0: got %h want %h", g, w); end
        reg_read(adr(1, 0), 32'h8000_0320, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL rate_ch1: got %h want %h", g, w); end
        reg_read(adr(2, 0), 32'h8000_0000, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL rate_ch2_stuck: got %h want %h", g, w); end
        reg_read(adr(0, 3), 32'h0000_0001, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL status_ch0_clean: got %h want %h", g, w); end
        n_run++; if ({alarm, irq} !== 4'b0000) begin n_fail++; $display("FAIL rate_no_alarm: got %b want 0000", {alarm, irq}); end
    endtask

    task automatic test_limits();
        logic [31:0] g, w;
        logic a;
        reg_write(adr(0, 2), 32'h00C8_006E, a);
        reg_read(adr(0, 2), 32'h00C8_006E, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL limits_readback: got %h want %h", g, w); end
        go_to(2999);
        reg_write(adr(1, 2), 32'hFFFF_0096, a);
        go_to(3001);
        n_run++; if ({alarm, irq} !== 4'b0011) begin n_fail++; $display("FAIL slow_alarm: got %b want 0011", {alarm, irq}); end
        reg_read(adr(0, 3), 32'h0000_0003, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL status_too_slow: got %h want %h", g, w); end
        ratio[0] = 6;
        reg_write(adr(0, 3), 32'h0000_0002, a);
        n_run++; if ({alarm, irq} !== 4'b0000) begin n_fail++; $display("FAIL w1c_alarm_drop: got %b want 0000", {alarm, irq}); end
        go_to(4005);
        reg_read(adr(0, 3), 32'h0000_0001, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL status_in_range: got %h want %h", g, w); end
        n_run++; if (alarm !== 3'b010) begin n_fail++; $display("FAIL late_limit_alarm: got %b want 010", alarm); end
        reg_write(adr(1, 2), 32'hFFFF_0000, a);
        reg_write(adr(1, 3), 32'h0000_000E, a);
        n_run++; if (alarm !== 3'b000) begin n_fail++; $display("FAIL ch1_cleared: got %b want 000", alarm); end
    endtask

    task automatic test_unlock();
        logic [31:0] g, w;
        logic a;
        for (int i = 0; i < 3; i++) begin
            locked[1] = 1'b0; repeat (3) tick();
            locked[1] = 1'b1; repeat (3) tick();
        end
        repeat (3) tick();
        reg_read(adr(1, 1), 32'd3, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL unlocks_3: got %h want %h", g, w); end
        locked[1] = 1'b0;
        tick();
        tick();
        reg_write(adr(1, 1), 32'h0, a);
        locked[1] = 1'b1;
        repeat (4) tick();
        reg_read(adr(1, 1), 32'd1, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL unlocks_clear_vs_edge: got %h want %h", g, w); end
        reg_read(adr(1, 3), 32'h0000_0009, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL status_unlock: got %h want %h", g, w); end
        n_run++; if ({alarm, irq} !== 4'b0101) begin n_fail++; $display("FAIL unlock_alarm: got %b want 0101", {alarm, irq}); end
        reg_write(adr(1, 3), 32'h0000_0008, a);
        n_run++; if (alarm !== 3'b000) begin n_fail++; $display("FAIL unlock_w1c: got %b want 000", alarm); end
    endtask

    task automatic test_stuck();
        logic [31:0] g, w;
        logic a;
        int k, m;
        reg_write(adr(2, 2), 32'hFFFF_0001, a);
        k = cyc - rst_edge;
        m = k / GATE + 1;
        if (m * GATE - k < 4) m++;
        go_to(m * GATE);
        reg_write(adr(2, 3), 32'h0000_0002, a);
        reg_read(adr(2, 3), 32'h0000_0003, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL set_beats_w1c: got %h want %h", g, w); end
        reg_read(adr(2, 0), 32'h8000_0000, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL stuck_rate: got %h want %h", g, w); end
        n_run++; if (alarm !== 3'b100) begin n_fail++; $display("FAIL stuck_alarm: got %b want 100", alarm); end
        go_to(m * GATE + 10);
        reg_write(adr(2, 3), 32'h0000_0002, a);
        reg_read(adr(2, 3), 32'h0000_0001, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL stuck_w1c_later: got %h want %h", g, w); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] g, w;
        logic a;
        int k;
        k = cyc - rst_edge;
        go_to((k / GATE + 1) * GATE + 500);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        rst_edge = cyc;
        reg_read(adr(0, 0), 32'h0000_0000, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL mid_reset_rate: got %h want %h", g, w); end
        for (int r = 0; r < 4; r++) begin
            reg_read(adr(3, r), 32'h0000_0000, g, w, a);
            n_run++; if (g !== w || a !== 1'b1) begin n_fail++; $display("FAIL oor_read_r%0d: got %h ack %b want %h ack 1", r, g, a, w); end
        end
        reg_write(adr(3, 2), 32'h1234_5678, a);
        n_run++; if (a !== 1'b1) begin n_fail++; $display("FAIL oor_wrack: got %b want 1", a); end
        reg_read(adr(0, 2), 32'hFFFF_0000, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL mid_reset_limits_ch0: got %h want %h", g, w); end
        reg_read(adr(2, 2), 32'hFFFF_0000, g, w, a);
        n_run++; if (g !== w) begin n_fail++; $display("FAIL mid_reset_limits_ch2: got %h want %h", g, w); end
        n_run++; if ({alarm, irq} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_alarm: got %b want 0000", {alarm, irq}); end
        go_to(GATE - 1);
        reg_read(adr(0, 0), 32'h0000_0000, g, w, a);
        n_run++; if ((g & 32'h8000_0000) !== w) begin n_fail++; $display("FAIL valid_before_window: got %h want %h", g & 32'h8000_0000, w); end
        reg_read(adr(0, 0), 32'h8000_0000, g, w, a);
        n_run++; if ((g & 32'h8000_0000) !== w) begin n_fail++; $display("FAIL valid_after_window: got %h want %h", g & 32'h8000_0000, w); end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_limits();
        test_unlock();
        test_stuck();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
